// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   This is the ID-stage hazard unit. It keeps one countdown per architectural
//   register. A countdown is nonzero while a write to that register is still in
//   flight and its result cannot yet be read by the instruction in ID. While
//   any source register that the ID instruction reads is pending, the unit
//   holds PC and IF/ID and inserts a bubble into ID/EX.
//
// Configuration macro:
//   HAZ_NOFWD_EN  undefined : forwarding is present. A load blocks its
//                             consumers for LOAD_LAT cycles. ALU writers never
//                             block.
//                 defined   : there is no bypass network. Every writer blocks
//                             its consumers until the register file has been
//                             written.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   synchronous reset, active low
//   id_valid  in   id_instr holds a real instruction
//   id_instr  in   instruction currently in ID (RV32I encoding)
//   mem_stall in   data memory not ready; the whole pipeline is frozen
//   flush     in   taken branch/jump in EX; the ID instruction is killed
//   stall     out  hold PC and IF/ID, bubble into ID/EX (combinational)
//   issue     out  ID instruction moves into EX this cycle (combinational)
//   busy_vec  out  bit r set while register r has a pending write
//
// Handshake: id_valid works as "valid". The acceptance strobe is issue, and it
// depends on stall, flush and mem_stall. An instruction is consumed only in a
// cycle where id_valid and issue are both high. Otherwise it stays in ID. A
// flushed instruction is dropped by the surrounding pipeline.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1,
  parameter int WB_DIST  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic                mem_stall,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int CW = $clog2(WB_DIST + LOAD_LAT + 1);

  // Countdown value loaded when an instruction issues.
`ifdef HAZ_NOFWD_EN
  localparam logic [CW-1:0] V_LOAD = CW'(WB_DIST + LOAD_LAT - 1);
  localparam logic [CW-1:0] V_ALU  = CW'(WB_DIST);
`else
  localparam logic [CW-1:0] V_LOAD = CW'(LOAD_LAT);
  localparam logic [CW-1:0] V_ALU  = '0;
`endif

  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       uses_rs1, uses_rs2, writes_rd, is_load;
  logic       rs1_busy, rs2_busy;
  logic [CW-1:0] v_issue;

  // funct3/funct7 play no part in the hazard check.
  logic unused_fields;
  assign unused_fields = ^{id_instr[31:25], id_instr[14:12]};

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end // OP
      7'b0010011: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end                   // OP-IMM
      7'b0000011: begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end   // LOAD
      7'b1100111: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end                   // JALR
      7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end                    // STORE
      7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end                    // BRANCH
      7'b1101111: writes_rd = 1'b1;                                              // JAL
      7'b0110111: writes_rd = 1'b1;                                              // LUI
      7'b0010111: writes_rd = 1'b1;                                              // AUIPC
      default: ;
    endcase
    // A write to x0 is discarded, so it never creates an entry.
    if (rd == 5'd0) writes_rd = 1'b0;
  end

  assign v_issue = is_load ? V_LOAD : V_ALU;

  // Look up the pending state of each source. The loop starts at 1, so x0
  // never reports busy. Register indices at or above NUM_REGS are not tracked.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (rs1 == 5'(r) && cnt_q[r] != '0) rs1_busy = 1'b1;
      if (rs2 == 5'(r) && cnt_q[r] != '0) rs2_busy = 1'b1;
    end
  end

  assign stall = id_valid & ~flush & ((uses_rs1 & rs1_busy) | (uses_rs2 & rs2_busy));
  assign issue = id_valid & ~flush & ~stall & ~mem_stall;

  // Every counter ages by one in each unfrozen cycle. A new write loads the
  // larger of its own latency and the aged old value. This keeps a younger
  // writer from retiring an older, longer pending write to the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!mem_stall) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CW'(1);
        if (r != 0 && issue && writes_rd && rd == 5'(r) && v_issue > cnt_d[r])
          cnt_d[r] = v_issue;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) busy_vec[r] = (cnt_q[r] != '0);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// This bench has two instances that share one stimulus. Instance a uses
// LOAD_LAT=1 and instance b uses LOAD_LAT=3. Each instance is compared against
// a reference model. The model gives each register an absolute "ready time",
// counted in unfrozen cycles. A register is pending while that ready time is
// still in the future. Directed scenarios run first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int NR = 32;
  localparam int WB = 3;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        clk = 1'b0;
  logic        reset_n, id_valid, mem_stall, flush;
  logic [31:0] id_instr;
  logic        stall_a, issue_a, stall_b, issue_b;
  logic [NR-1:0] busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  // Model state: ready time per register for each instance, plus the count
  // of unfrozen cycles that have elapsed.
  int rdy_a [NR];
  int rdy_b [NR];
  int t_now = 0;

  // Values observed in the most recent step. The directed checks use them.
  logic obs_stall_a, obs_stall_b, obs_issue_a, obs_issue_b;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(NR), .LOAD_LAT(LAT_A), .WB_DIST(WB)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr),
    .mem_stall(mem_stall), .flush(flush), .stall(stall_a), .issue(issue_a),
    .busy_vec(busy_a));

  hazard_scoreboard #(.NUM_REGS(NR), .LOAD_LAT(LAT_B), .WB_DIST(WB)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr),
    .mem_stall(mem_stall), .flush(flush), .stall(stall_b), .issue(issue_b),
    .busy_vec(busy_b));

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h004, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h001, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'b0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  // ---------------- reference model ----------------
  function automatic void decode(input logic [31:0] ins, output bit u1, output bit u2,
                                 output bit wr, output bit ld);
    logic [6:0] op;
    op = ins[6:0];
    u1 = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
         (op == 7'b1100111) || (op == 7'b0100011) || (op == 7'b1100011);
    u2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    wr = ((op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
          (op == 7'b1100111) || (op == 7'b1101111) || (op == 7'b0110111) ||
          (op == 7'b0010111)) && (ins[11:7] != 5'd0);
    ld = (op == 7'b0000011);
  endfunction

  function automatic int issue_val(input bit ld, input int lat);
`ifdef HAZ_NOFWD_EN
    return ld ? (WB + lat - 1) : WB;
`else
    return ld ? lat : 0;
`endif
  endfunction

  function automatic bit pend(input int which, input int r);
    if (r == 0) return 1'b0;
    return (which == 0) ? (rdy_a[r] > t_now) : (rdy_b[r] > t_now);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle. Inputs are driven just after the rising edge. Outputs
  // are checked on the falling edge. The model then advances at the next
  // rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic ms,
                      input logic fl, input logic rn);
    bit u1, u2, wr, ld;
    bit es_a, es_b, ei_a, ei_b;
    logic [NR-1:0] eb_a, eb_b;
    int rd, s1, s2, nr_a, nr_b;
    id_valid = v; id_instr = ins; mem_stall = ms; flush = fl; reset_n = rn;
    decode(ins, u1, u2, wr, ld);
    rd = int'(ins[11:7]); s1 = int'(ins[19:15]); s2 = int'(ins[24:20]);
    es_a = v && !fl && ((u1 && pend(0, s1)) || (u2 && pend(0, s2)));
    es_b = v && !fl && ((u1 && pend(1, s1)) || (u2 && pend(1, s2)));
    ei_a = v && !fl && !es_a && !ms;
    ei_b = v && !fl && !es_b && !ms;
    eb_a = '0; eb_b = '0;
    for (int r = 1; r < NR; r++) begin
      eb_a[r] = pend(0, r);
      eb_b[r] = pend(1, r);
    end
    @(negedge clk);
    chk("stall_a", 32'(stall_a), 32'(es_a));
    chk("issue_a", 32'(issue_a), 32'(ei_a));
    chk("busy_a",  32'(busy_a),  32'(eb_a));
    chk("stall_b", 32'(stall_b), 32'(es_b));
    chk("issue_b", 32'(issue_b), 32'(ei_b));
    chk("busy_b",  32'(busy_b),  32'(eb_b));
    obs_stall_a = stall_a; obs_stall_b = stall_b;
    obs_issue_a = issue_a; obs_issue_b = issue_b;
    @(posedge clk);
    if (!rn) begin
      for (int r = 0; r < NR; r++) begin rdy_a[r] = 0; rdy_b[r] = 0; end
      t_now = 0;
    end else if (!ms) begin
      if (ei_a && wr) begin
        nr_a = t_now + 1 + issue_val(ld, LAT_A);
        if (nr_a > rdy_a[rd]) rdy_a[rd] = nr_a;
      end
      if (ei_b && wr) begin
        nr_b = t_now + 1 + issue_val(ld, LAT_B);
        if (nr_b > rdy_b[rd]) rdy_b[rd] = nr_b;
      end
      t_now++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0000_0013, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef HAZ_NOFWD_EN
  localparam int EXP_LD_A  = WB + LAT_A - 1;
  localparam int EXP_LD_B  = WB + LAT_B - 1;
  localparam int EXP_ALU   = WB;
`else
  localparam int EXP_LD_A  = LAT_A;
  localparam int EXP_LD_B  = LAT_B;
  localparam int EXP_ALU   = 0;
`endif

  int sc_a, sc_b;
  logic [31:0] op_tbl [10];

  initial begin
    op_tbl[0] = 32'h33; op_tbl[1] = 32'h13; op_tbl[2] = 32'h03; op_tbl[3] = 32'h67;
    op_tbl[4] = 32'h23; op_tbl[5] = 32'h63; op_tbl[6] = 32'h6f; op_tbl[7] = 32'h37;
    op_tbl[8] = 32'h17; op_tbl[9] = 32'h0f;
    for (int r = 0; r < NR; r++) begin rdy_a[r] = 0; rdy_b[r] = 0; end
    id_valid = 0; id_instr = 0; mem_stall = 0; flush = 0; reset_n = 0;
    @(posedge clk); #1;

    // Reset state.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_busy_a", 32'(busy_a), 32'h0);

    // A load followed by a dependent add that reads rs1.
    step(1'b1, i_lw(5'd5, 5'd1), 1'b0, 1'b0, 1'b1);
    sc_a = 0; sc_b = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i_add(5'd6, 5'd5, 5'd2), 1'b0, 1'b0, 1'b1);
      sc_a += int'(obs_stall_a); sc_b += int'(obs_stall_b);
    end
    chk("ld_use_len_a", 32'(sc_a), 32'(EXP_LD_A));
    chk("ld_use_len_b", 32'(sc_b), 32'(EXP_LD_B));
    idle(6);

    // A load followed by a dependent store that reads rs2.
    step(1'b1, i_lw(5'd5, 5'd1), 1'b0, 1'b0, 1'b1);
    sc_b = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i_sw(5'd5, 5'd2), 1'b0, 1'b0, 1'b1);
      sc_b += int'(obs_stall_b);
    end
    chk("ld_sw_len_b", 32'(sc_b), 32'(EXP_LD_B));
    idle(6);

    // Writes to x0 never track. An ALU producer is followed by its consumer.
    step(1'b1, i_lw(5'd0, 5'd1), 1'b0, 1'b0, 1'b1);
    step(1'b1, i_add(5'd6, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
    chk("x0_nostall", 32'(obs_stall_a), 32'h0);
    step(1'b1, i_addi(5'd7, 5'd7), 1'b0, 1'b0, 1'b1);
    sc_a = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i_add(5'd9, 5'd7, 5'd7), 1'b0, 1'b0, 1'b1);
      sc_a += int'(obs_stall_a);
    end
    chk("alu_use_len_a", 32'(sc_a), 32'(EXP_ALU));
    idle(6);

    // A freeze right after the load extends the stall.
    step(1'b1, i_lw(5'd5, 5'd1), 1'b0, 1'b0, 1'b1);
    step(1'b1, i_add(5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1);
    step(1'b1, i_add(5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1);
    step(1'b1, i_add(5'd6, 5'd5, 5'd2), 1'b0, 1'b0, 1'b1);
    step(1'b1, i_add(5'd6, 5'd5, 5'd2), 1'b0, 1'b0, 1'b1);
    idle(6);

    // Flush during the stall, then reset while an entry is pending.
    step(1'b1, i_lw(5'd5, 5'd1), 1'b0, 1'b0, 1'b1);
    step(1'b1, i_add(5'd6, 5'd5, 5'd2), 1'b0, 1'b1, 1'b1);
    chk("flush_stall_a", 32'(obs_stall_a), 32'h0);
    chk("flush_issue_a", 32'(obs_issue_a), 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, i_add(5'd6, 5'd5, 5'd2), 1'b0, 1'b0, 1'b1);
    chk("post_reset_issue_b", 32'(obs_issue_b), 32'h1);
    idle(6);

    // Two loads write x8 in turn, then a consumer reads x8.
    step(1'b1, i_lw(5'd8, 5'd1), 1'b0, 1'b0, 1'b1);
    step(1'b1, i_lw(5'd8, 5'd2), 1'b0, 1'b0, 1'b1);
    sc_b = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i_add(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 1'b1);
      sc_b += int'(obs_stall_b);
    end
    chk("waw_len_b", 32'(sc_b), 32'(EXP_LD_B));
    idle(6);

    // Randomized phase. Registers come from a small pool so hazards are common.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      ins = op_tbl[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 5));
      ins[19:15] = 5'($urandom_range(0, 5));
      ins[24:20] = 5'($urandom_range(0, 5));
      step(1'($urandom_range(0, 9) != 0), ins, 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
